strip_trailer: RTL and testbench

Parametrised successor to the fixed 4-byte CRC stripper in the MII MAC receive path. It removes the last `TRAILER_BYTES` bytes of every AXI-Stream byte frame and forwards the rest at full throughput, with no inter-frame bubble. It latches the stripped trailer and, when enabled, checks it as an Ethernet FCS. It sits between the MII receiver/preamble stripper and the frame parser.

---
 rtl/eth_pkg.sv | 26 ++
 rtl/crc32_byte_update.sv | 13 +
 rtl/strip_trailer.sv | 185 ++++++++++++++++++
 tb/tb_strip_trailer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the MAC receive/transmit paths:
// CRC-32 constants, the trailer stripper state type and a byte-wise CRC step.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    typedef enum logic {
        S_FILL,
        S_PASS
    } state_t;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc32_byte(
        input logic [31:0] crc,
        input logic [7:0]  data
    );
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_byte_update.sv
// Combinational single-byte CRC-32 step.
// Shared between the FCS checker and the transmit FCS inserter.
module crc32_byte_update
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    assign crc_o = crc32_byte(crc_i, data_i);

endmodule

// File: rtl/strip_trailer.sv
// Strips the last TRAILER_BYTES bytes of each AXI-Stream byte frame,
// latches them as the trailer and optionally checks them as an Ethernet FCS.
module strip_trailer
    import eth_pkg::*;
#(
    parameter int TRAILER_BYTES = 4,
    parameter int CHECK_CRC     = 1,
    parameter int CNT_W         = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [7:0]                 saxis_tdata,
    input  logic                       saxis_tvalid,
    output logic                       saxis_tready,
    input  logic                       saxis_tlast,
    input  logic                       saxis_tuser,
    output logic [7:0]                 maxis_tdata,
    output logic                       maxis_tvalid,
    input  logic                       maxis_tready,
    output logic                       maxis_tlast,
    output logic                       maxis_tuser,
    output logic [8*TRAILER_BYTES-1:0] trailer,
    output logic                       trailer_valid,
    output logic [CNT_W-1:0]           frame_count,
    output logic [CNT_W-1:0]           runt_count,
    output logic [CNT_W-1:0]           crc_error_count
);

    localparam int FW = $clog2(TRAILER_BYTES + 1);
    localparam int TW = 8 * TRAILER_BYTES;
    localparam logic [FW-1:0] FULL = FW'(TRAILER_BYTES);

    state_t           state_q, state_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [TW-1:0]    buf_q, buf_d, buf_shift;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic             m_user_q, m_user_d;
    logic [TW-1:0]    trailer_q, trailer_d;
    logic             trl_vld_q, trl_vld_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] runt_cnt_q, runt_cnt_d;
    logic [CNT_W-1:0] crc_err_q, crc_err_d;
    logic             err_q, err_d;
    logic [31:0]      crc_q, crc_d, crc_next;
    logic             crc_bad;
    logic             acc, emit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign saxis_tready = (state_q == S_FILL) || !m_valid_q || maxis_tready;
    assign acc  = saxis_tvalid && saxis_tready;
    assign emit = m_valid_q && maxis_tready;

    // Delay line advanced by one byte; byte 0 is the oldest. After the last
    // byte this is also exactly the trailer, first trailer byte lowest.
    always_comb begin
        buf_shift = buf_q;
        for (int i = 0; i < TRAILER_BYTES - 1; i++) begin
            buf_shift[8*i +: 8] = buf_q[8*(i+1) +: 8];
        end
        buf_shift[TW-8 +: 8] = saxis_tdata;
    end

    generate
        if (CHECK_CRC != 0) begin : g_crc
            crc32_byte_update u_crc (
                .crc_i  (crc_q),
                .data_i (buf_q[7:0]),
                .crc_o  (crc_next)
            );
            assign crc_bad = (~crc_next != buf_shift[31:0]);
        end else begin : g_no_crc
            assign crc_next = crc_q;
            assign crc_bad  = 1'b0;
        end
    endgenerate

    // Next-state: fill/pass sequencing, output register, trailer and stats.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        buf_d       = buf_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_user_d    = m_user_q;
        trailer_d   = trailer_q;
        trl_vld_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        runt_cnt_d  = runt_cnt_q;
        crc_err_d   = crc_err_q;
        err_d       = err_q;
        crc_d       = crc_q;
        if (emit) begin
            m_valid_d = 1'b0;
        end
        if (acc) begin
            buf_d = buf_shift;
            err_d = err_q | saxis_tuser;
            unique case (state_q)
                S_FILL: begin
                    if (saxis_tlast) begin
                        fill_d     = '0;
                        runt_cnt_d = sat_inc(runt_cnt_q);
                        err_d      = 1'b0;
                        crc_d      = CRC32_INIT;
                    end else begin
                        fill_d = fill_q + FW'(1);
                    end
                end
                S_PASS: begin
                    m_data_d  = buf_q[7:0];
                    m_valid_d = 1'b1;
                    m_last_d  = saxis_tlast;
                    m_user_d  = 1'b0;
                    crc_d     = crc_next;
                    if (saxis_tlast) begin
                        trailer_d   = buf_shift;
                        trl_vld_d   = 1'b1;
                        frame_cnt_d = sat_inc(frame_cnt_q);
                        fill_d      = '0;
                        m_user_d    = err_q | saxis_tuser | crc_bad;
                        if (crc_bad) begin
                            crc_err_d = sat_inc(crc_err_q);
                        end
                        err_d = 1'b0;
                        crc_d = CRC32_INIT;
                    end
                end
                default: ;
            endcase
        end
        state_d = (fill_d == FULL) ? S_PASS : S_FILL;
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_FILL;
            fill_q      <= '0;
            buf_q       <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_user_q    <= 1'b0;
            trailer_q   <= '0;
            trl_vld_q   <= 1'b0;
            frame_cnt_q <= '0;
            runt_cnt_q  <= '0;
            crc_err_q   <= '0;
            err_q       <= 1'b0;
            crc_q       <= CRC32_INIT;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            buf_q       <= buf_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_user_q    <= m_user_d;
            trailer_q   <= trailer_d;
            trl_vld_q   <= trl_vld_d;
            frame_cnt_q <= frame_cnt_d;
            runt_cnt_q  <= runt_cnt_d;
            crc_err_q   <= crc_err_d;
            err_q       <= err_d;
            crc_q       <= crc_d;
        end
    end

    assign maxis_tdata     = m_data_q;
    assign maxis_tvalid    = m_valid_q;
    assign maxis_tlast     = m_last_q;
    assign maxis_tuser     = m_user_q;
    assign trailer         = trailer_q;
    assign trailer_valid   = trl_vld_q;
    assign frame_count     = frame_cnt_q;
    assign runt_count      = runt_cnt_q;
    assign crc_error_count = crc_err_q;

endmodule

// File: tb/tb_strip_trailer.sv
// Self-checking bench for strip_trailer: a 4-byte FCS-checking instance
// and a 2-byte non-checking instance, with a scoreboard per instance.
module tb_strip_trailer;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_last, s_user, s_valid_a, s_valid_b;
    logic        m_ready_a, m_ready_b;

    logic        a_srdy, a_mv, a_ml, a_mu, a_tv;
    logic [7:0]  a_md;
    logic [31:0] a_trl;
    logic [15:0] a_fc, a_rc, a_cc;
    logic        b_srdy, b_mv, b_ml, b_mu, b_tv;
    logic [7:0]  b_md;
    logic [15:0] b_trl;
    logic [15:0] b_fc, b_rc, b_cc;

    always #5 clock = ~clock;

    strip_trailer #(.TRAILER_BYTES(4), .CHECK_CRC(1), .CNT_W(16)) dut_a (
        .clock(clock), .reset(reset),
        .saxis_tdata(s_data), .saxis_tvalid(s_valid_a), .saxis_tready(a_srdy),
        .saxis_tlast(s_last), .saxis_tuser(s_user),
        .maxis_tdata(a_md), .maxis_tvalid(a_mv), .maxis_tready(m_ready_a),
        .maxis_tlast(a_ml), .maxis_tuser(a_mu),
        .trailer(a_trl), .trailer_valid(a_tv),
        .frame_count(a_fc), .runt_count(a_rc), .crc_error_count(a_cc)
    );

    strip_trailer #(.TRAILER_BYTES(2), .CHECK_CRC(0), .CNT_W(16)) dut_b (
        .clock(clock), .reset(reset),
        .saxis_tdata(s_data), .saxis_tvalid(s_valid_b), .saxis_tready(b_srdy),
        .saxis_tlast(s_last), .saxis_tuser(s_user),
        .maxis_tdata(b_md), .maxis_tvalid(b_mv), .maxis_tready(m_ready_b),
        .maxis_tlast(b_ml), .maxis_tuser(b_mu),
        .trailer(b_trl), .trailer_valid(b_tv),
        .frame_count(b_fc), .runt_count(b_rc), .crc_error_count(b_cc)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    typedef struct {
        int          kind;
        int          err_pos;
        int          fr_exp;
        int          rn_exp;
        int          ce_exp;
        logic [31:0] trl_exp;
    } vec_t;

    beat_t      qa[$];
    beat_t      qb[$];
    logic [7:0] fr[$];
    logic       fu[$];
    int         total = 0;
    int         bad = 0;
    int         tlast_a = 0, tv_a = 0, tlast_b = 0, tv_b = 0;
    bit         mon_en = 1'b1;
    bit         rnd_a = 1'b0;
    bit         hold_v = 1'b0;
    logic [7:0] hold_d;
    logic       hold_l;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, fr[i]};
            for (int k = 0; k < 8; k++) begin
                if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
                else      c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic build(input int kind, input int err_pos);
        logic [31:0] c;
        fr.delete();
        fu.delete();
        case (kind)
            0, 1: begin
                for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
                fr.push_back(8'h26);
                fr.push_back(8'h39);
                fr.push_back(8'hF4);
                fr.push_back(8'hCB);
                if (kind == 1) fr[12] = 8'hCC;
            end
            2: for (int i = 0; i < 4; i++) fr.push_back(8'hE0 + 8'(i));
            3: fr.push_back(8'hF0);
            4: for (int i = 0; i < 5; i++) fr.push_back(8'h01 + 8'(i));
            5: begin
                for (int i = 0; i < 60; i++) fr.push_back(8'($urandom_range(0, 255)));
                c = crc_of(60);
                fr.push_back(c[7:0]);
                fr.push_back(c[15:8]);
                fr.push_back(c[23:16]);
                fr.push_back(c[31:24]);
            end
            6: for (int i = 0; i < 10; i++) fr.push_back(8'hA0 + 8'(i));
            7: for (int i = 0; i < 10; i++) fr.push_back(8'hB0 + 8'(i));
            8: for (int i = 0; i < 10; i++) fr.push_back(8'hC0 + 8'(i));
            default: ;
        endcase
        for (int i = 0; i < fr.size(); i++) fu.push_back(1'b0);
        if (err_pos >= 0) fu[err_pos] = 1'b1;
    endtask

    task automatic push_exp(input bit to_a, input int tb, input bit crc_en);
        int          n, p;
        logic        err, cb;
        logic [31:0] tw;
        beat_t       e;
        n = fr.size();
        if (n > tb) begin
            p = n - tb;
            err = 1'b0;
            for (int i = 0; i < n; i++) err = err | fu[i];
            cb = 1'b0;
            if (crc_en) begin
                tw = {fr[n-1], fr[n-2], fr[n-3], fr[n-4]};
                cb = (crc_of(p) != tw);
            end
            for (int i = 0; i < p; i++) begin
                e.d = fr[i];
                e.l = (i == p - 1);
                e.u = (i == p - 1) ? (err | cb) : 1'b0;
                if (to_a) qa.push_back(e);
                else      qb.push_back(e);
            end
        end
    endtask

    task automatic send(input bit to_a, input int cnt, output bit rdy_all);
        int w;
        bit r;
        rdy_all = 1'b1;
        for (int i = 0; i < cnt; i++) begin
            s_data = fr[i];
            s_user = fu[i];
            s_last = (i == fr.size() - 1);
            if (to_a) s_valid_a = 1'b1;
            else      s_valid_b = 1'b1;
            w = 0;
            forever begin
                @(negedge clock);
                r = to_a ? a_srdy : b_srdy;
                if (!r) rdy_all = 1'b0;
                @(posedge clock);
                #1;
                if (r) break;
                w++;
                if (w > 500) begin
                    total++;
                    bad++;
                    $display("FAIL send_timeout: got tready=0 want 1 within 500 cycles");
                    break;
                end
            end
        end
        s_valid_a = 1'b0;
        s_valid_b = 1'b0;
        s_last = 1'b0;
        s_user = 1'b0;
    endtask

    task automatic drain(input bit to_a);
        int w;
        w = 0;
        while (w < 300 && (to_a ? (qa.size() != 0 || a_mv) : (qb.size() != 0 || b_mv))) begin
            @(posedge clock);
            #1;
            w++;
        end
        chk(to_a ? "drain_a" : "drain_b", 64'(to_a ? qa.size() : qb.size()), 64'(0));
    endtask

    always @(posedge clock) begin
        #1;
        m_ready_a = rnd_a ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    always @(negedge clock) begin
        beat_t e;
        if (reset || !mon_en) begin
            hold_v = 1'b0;
        end else begin
            if (a_tv) tv_a++;
            if (b_tv) tv_b++;
            if (hold_v) chk("hold_a", 64'({a_mv, a_md, a_ml}), 64'({1'b1, hold_d, hold_l}));
            hold_v = 1'b0;
            if (a_mv && !m_ready_a) begin
                hold_v = 1'b1;
                hold_d = a_md;
                hold_l = a_ml;
            end
            if (a_mv && m_ready_a) begin
                if (qa.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_a: got unexpected beat %0h want none", a_md);
                end else begin
                    e = qa.pop_front();
                    chk("beat_a", 64'({a_md, a_ml, a_mu}), 64'({e.d, e.l, e.u}));
                end
                if (a_ml) tlast_a++;
            end
            if (b_mv && m_ready_b) begin
                if (qb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_b: got unexpected beat %0h want none", b_md);
                end else begin
                    e = qb.pop_front();
                    chk("beat_b", 64'({b_md, b_ml, b_mu}), 64'({e.d, e.l, e.u}));
                end
                if (b_ml) tlast_b++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        bit   ra;
        tbl[0] = '{0, -1, 1, 0, 0, 32'hCBF43926};
        tbl[1] = '{1, -1, 2, 0, 1, 32'hCCF43926};
        tbl[2] = '{2, -1, 2, 1, 1, 32'hCCF43926};
        tbl[3] = '{3, -1, 2, 2, 1, 32'hCCF43926};
        tbl[4] = '{4, -1, 3, 2, 2, 32'h05040302};
        tbl[5] = '{0, 10, 4, 2, 2, 32'hCBF43926};
        tbl[6] = '{0, -1, 5, 2, 2, 32'hCBF43926};

        reset = 1'b1;
        s_data = 8'h00;
        s_last = 1'b0;
        s_user = 1'b0;
        s_valid_a = 1'b0;
        s_valid_b = 1'b0;
        m_ready_a = 1'b1;
        m_ready_b = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_mout", 64'({a_mv, a_ml, a_mu, a_md}), 64'(0));
        chk("rst_trl", 64'({a_trl, a_tv}), 64'(0));
        chk("rst_cnt", 64'({a_fc, a_rc, a_cc}), 64'(0));
        chk("rst_srdy", 64'(a_srdy), 64'(1));
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int v = 0; v < 7; v++) begin
            build(tbl[v].kind, tbl[v].err_pos);
            push_exp(1'b1, 4, 1'b1);
            send(1'b1, fr.size(), ra);
            drain(1'b1);
            chk($sformatf("frames_%0d", v), 64'(a_fc), 64'(tbl[v].fr_exp));
            chk($sformatf("runts_%0d", v), 64'(a_rc), 64'(tbl[v].rn_exp));
            chk($sformatf("crcerr_%0d", v), 64'(a_cc), 64'(tbl[v].ce_exp));
            chk($sformatf("trailer_%0d", v), 64'(a_trl), 64'(tbl[v].trl_exp));
            chk($sformatf("tvpulse_%0d", v), 64'(tv_a), 64'(tbl[v].fr_exp));
            chk($sformatf("tlasts_%0d", v), 64'(tlast_a), 64'(tbl[v].fr_exp));
            chk($sformatf("srdy_%0d", v), 64'(ra), 64'(1));
        end

        rnd_a = 1'b1;
        build(5, -1);
        push_exp(1'b1, 4, 1'b1);
        send(1'b1, fr.size(), ra);
        build(5, -1);
        push_exp(1'b1, 4, 1'b1);
        send(1'b1, fr.size(), ra);
        drain(1'b1);
        rnd_a = 1'b0;
        chk("b2b_frames", 64'(a_fc), 64'(7));
        chk("b2b_crcerr", 64'(a_cc), 64'(2));
        chk("b2b_tlasts", 64'(tlast_a), 64'(7));

        build(6, -1);
        push_exp(1'b0, 2, 1'b0);
        send(1'b0, fr.size(), ra);
        drain(1'b0);
        chk("b_trailer", 64'(b_trl), 64'(16'hA9A8));
        chk("b_frames", 64'(b_fc), 64'(1));
        chk("b_crcerr", 64'(b_cc), 64'(0));
        chk("b_tlasts", 64'(tlast_b), 64'(1));

        build(7, -1);
        mon_en = 1'b0;
        send(1'b0, 6, ra);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("mrst_bout", 64'({b_mv, b_ml, b_mu, b_md}), 64'(0));
        chk("mrst_btrl", 64'({b_trl, b_tv}), 64'(0));
        chk("mrst_bcnt", 64'({b_fc, b_rc, b_cc}), 64'(0));
        chk("mrst_acnt", 64'({a_fc, a_trl}), 64'(0));
        qb.delete();
        reset = 1'b0;
        tlast_b = 0;
        tv_b = 0;
        mon_en = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        build(8, -1);
        push_exp(1'b0, 2, 1'b0);
        send(1'b0, fr.size(), ra);
        drain(1'b0);
        chk("post_frames", 64'(b_fc), 64'(1));
        chk("post_trailer", 64'(b_trl), 64'(16'hC9C8));
        chk("post_tlasts", 64'(tlast_b), 64'(1));
        chk("post_tv", 64'(tv_b), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
